// File: rtl/max6682_spi_responder.sv
// rtl/max6682_spi_responder.sv - MAX6682 SPI slave emulator with conversion timer; optional MAX6682_RESP_ERRCNT_EN
module max6682_spi_responder #(
    parameter int CONV_CYCLES = 1000,
    parameter int TEMP_WIDTH  = 11
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic [10:0] Temperature_i,
    input  logic        SCK_i,
    input  logic        CS_n_i,
    output logic        MISO_o,
    output logic        MISO_En_o,
    output logic        FrameDone_o,
    output logic        ConvBusy_o,
    output logic [7:0]  FrameErrCnt_o
);

    localparam logic [15:0] TIMER_TERM = 16'(CONV_CYCLES - 1);
    localparam int          PAD_BITS   = 16 - TEMP_WIDTH;

    typedef enum logic [1:0] {
        ST_CONVERT = 2'd0,
        ST_READY   = 2'd1,
        ST_SHIFT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [10:0] value_q, value_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    logic sck_s1_q, sck_s2_q, sck_dly_q;
    logic cs_s1_q, cs_s2_q, cs_dly_q;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    // Idle levels (SCK low, CS high) on reset so no spurious edge follows reset release
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_dly_q <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_dly_q  <= 1'b1;
        end else begin
            sck_s1_q  <= SCK_i;
            sck_s2_q  <= sck_s1_q;
            sck_dly_q <= sck_s2_q;
            cs_s1_q   <= CS_n_i;
            cs_s2_q   <= cs_s1_q;
            cs_dly_q  <= cs_s2_q;
        end
    end

    assign sck_rise = sck_s2_q & ~sck_dly_q;
    assign sck_fall = ~sck_s2_q & sck_dly_q;
    assign cs_fall  = ~cs_s2_q & cs_dly_q;
    assign cs_rise  = cs_s2_q & ~cs_dly_q;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= ST_CONVERT;
            timer_q <= 16'd0;
            value_q <= 11'd0;
            shift_q <= 16'd0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            value_q <= value_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        value_d = value_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_CONVERT: begin
                // A select during conversion aborts it and ships the held value
                if (cs_fall) begin
                    shift_d = {value_q, {PAD_BITS{1'b0}}};
                    cnt_d   = 5'd0;
                    state_d = ST_SHIFT;
                end else if (timer_q == TIMER_TERM) begin
                    value_d = Temperature_i;
                    state_d = ST_READY;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_READY: begin
                if (cs_fall) begin
                    shift_d = {value_q, {PAD_BITS{1'b0}}};
                    cnt_d   = 5'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    timer_d = 16'd0;
                    state_d = ST_CONVERT;
                end else if (sck_rise) begin
                    if (cnt_q != 5'd16) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                    if (cnt_q == 5'd15) begin
                        done_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    shift_d = {shift_q[14:0], 1'b0};
                end
            end
            default: begin
                state_d = ST_CONVERT;
                timer_d = 16'd0;
            end
        endcase
    end

    assign MISO_En_o   = (state_q == ST_SHIFT);
    assign MISO_o      = (state_q == ST_SHIFT) & shift_q[15];
    assign ConvBusy_o  = (state_q == ST_CONVERT);
    assign FrameDone_o = done_q;

`ifdef MAX6682_RESP_ERRCNT_EN
    logic [7:0] errcnt_q;
    logic       frame_trunc;

    assign frame_trunc = (state_q == ST_SHIFT) & cs_rise & (cnt_q < 5'd16);

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            errcnt_q <= 8'd0;
        end else if (frame_trunc && (errcnt_q != 8'hFF)) begin
            errcnt_q <= errcnt_q + 8'd1;
        end
    end

    assign FrameErrCnt_o = errcnt_q;
`else
    assign FrameErrCnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_max6682_spi_responder.sv
// tb/tb_max6682_spi_responder.sv - directed bench for max6682_spi_responder (CONV_CYCLES=20)
module tb_max6682_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] temp;
    logic        sck;
    logic        cs_n;
    logic        miso;
    logic        miso_en;
    logic        frame_done;
    logic        conv_busy;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;
    int fd_base;
    logic        busy_seen;
    logic [31:0] rx;
    logic [7:0]  err_exp_one;

    max6682_spi_responder #(.CONV_CYCLES(20), .TEMP_WIDTH(11)) dut (
        .Clk_i         (clk),
        .Reset_i       (rst),
        .Temperature_i (temp),
        .SCK_i         (sck),
        .CS_n_i        (cs_n),
        .MISO_o        (miso),
        .MISO_En_o     (miso_en),
        .FrameDone_o   (frame_done),
        .ConvBusy_o    (conv_busy),
        .FrameErrCnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drops CS_n, then clocks nbits at SCK = Clk/10, sampling MISO just before each rise
    task automatic read_bits(input int nbits, output logic [31:0] data, output logic busy);
        data = 32'd0;
        busy = 1'b0;
        cs_n = 1'b0;
        cyc(5);
        for (int i = 0; i < nbits; i++) begin
            data = {data[30:0], miso};
            if (conv_busy !== 1'b0) busy = 1'b1;
            sck = 1'b1;
            cyc(5);
            sck = 1'b0;
            cyc(5);
        end
    endtask

    initial begin
`ifdef MAX6682_RESP_ERRCNT_EN
        err_exp_one = 8'd1;
`else
        err_exp_one = 8'd0;
`endif
        rst  = 1'b1;
        temp = 11'h19C;
        sck  = 1'b0;
        cs_n = 1'b1;
        cyc(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_miso_en", {31'd0, miso_en}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_conv_busy", {31'd0, conv_busy}, 32'd1);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;

        // Basic read of 0x19C
        cyc(30);
        check("conv_done_busy", {31'd0, conv_busy}, 32'd0);
        fd_base = fd_cnt;
        read_bits(16, rx, busy_seen);
        check("read_19c", rx, 32'h0000_3380);
        check("read_19c_busy", {31'd0, busy_seen}, 32'd0);
        check("read_19c_fd", fd_cnt - fd_base, 32'd1);
        cs_n = 1'b1;
        temp = 11'h7FF;
        cyc(30);

        // Negative value, then a 20-bit over-read
        read_bits(16, rx, busy_seen);
        check("read_7ff", rx, 32'h0000_FFE0);
        cs_n = 1'b1;
        cyc(30);
        fd_base = fd_cnt;
        read_bits(20, rx, busy_seen);
        check("read20_word", rx[19:4], 32'h0000_FFE0);
        check("read20_tail", rx[3:0], 32'd0);
        check("read20_fd", fd_cnt - fd_base, 32'd1);

        // Early select aborts the conversion and ships the old value
        cs_n = 1'b1;
        temp = 11'h001;
        cyc(5);
        check("abort_busy_before", {31'd0, conv_busy}, 32'd1);
        cs_n = 1'b0;
        cyc(4);
        check("abort_busy_after", {31'd0, conv_busy}, 32'd0);
        check("abort_miso_en", {31'd0, miso_en}, 32'd1);
        read_bits(16, rx, busy_seen);
        check("abort_old_value", rx, 32'h0000_FFE0);
        check("abort_busy_flag", {31'd0, busy_seen}, 32'd0);
        cs_n = 1'b1;
        cyc(30);
        read_bits(16, rx, busy_seen);
        check("read_001", rx, 32'h0000_0020);

        // Truncated frame after 7 rising edges
        cs_n = 1'b1;
        cyc(30);
        fd_base = fd_cnt;
        read_bits(7, rx, busy_seen);
        cs_n = 1'b1;
        cyc(3);
        check("trunc_miso_en", {31'd0, miso_en}, 32'd0);
        check("trunc_miso", {31'd0, miso}, 32'd0);
        check("trunc_busy", {31'd0, conv_busy}, 32'd1);
        check("trunc_fd", fd_cnt - fd_base, 32'd0);
        check("trunc_err_cnt", {24'd0, err_cnt}, {24'd0, err_exp_one});

        // Reset mid-frame after 9 bits
        cyc(30);
        temp = 11'h0A5;
        read_bits(9, rx, busy_seen);
        check("midrst_pre_en", {31'd0, miso_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_miso_en", {31'd0, miso_en}, 32'd0);
        check("midrst_fd", {31'd0, frame_done}, 32'd0);
        check("midrst_busy", {31'd0, conv_busy}, 32'd1);
        check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
        cs_n = 1'b1;
        sck  = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(30);
        read_bits(16, rx, busy_seen);
        check("read_0a5", rx, 32'h0000_14A0);
        cs_n = 1'b1;
        cyc(5);

`ifdef MAX6682_RESP_ERRCNT_EN
        for (int f = 0; f < 300; f++) begin
            cs_n = 1'b0;
            cyc(4);
            cs_n = 1'b1;
            cyc(4);
        end
        check("errcnt_saturate", {24'd0, err_cnt}, 32'h0000_00FF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
